// File: rtl/control_unit_if.sv
// +----------------------------------------------------------------------+
// | control_unit_if: instruction fields, ALU status and datapath controls |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface control_unit_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Overflow;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       EQorNE;
  logic       MemRead_Write;
  logic       WDSrc;
  logic [2:0] IorD;
  logic       MDR;
  logic       IRWrite;
  logic       RegALoad;
  logic       RegBLoad;
  logic       ALUOutLoad;
  logic       EPCWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [3:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [2:0] PCSrc;
  logic [2:0] ShiftType;
  logic [1:0] ShiftQnt;
  logic [1:0] ShiftReg;
  logic [1:0] ExcCause;
  logic [4:0] State;

  modport master (
    input  Opcode, Funct, Overflow,
    output PCWrite, PCWriteCond, EQorNE, MemRead_Write, WDSrc, IorD, MDR,
           IRWrite, RegALoad, RegBLoad, ALUOutLoad, EPCWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, ShiftType,
           ShiftQnt, ShiftReg, ExcCause, State
  );

  modport slave (
    output Opcode, Funct, Overflow,
    input  PCWrite, PCWriteCond, EQorNE, MemRead_Write, WDSrc, IorD, MDR,
           IRWrite, RegALoad, RegBLoad, ALUOutLoad, EPCWrite, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSrc, ShiftType,
           ShiftQnt, ShiftReg, ExcCause, State
  );
endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// +----------------------------------------------------------------------+
// | control_unit: multicycle MIPS-subset control FSM with EPC exceptions |
// | Optional shifts enabled by macro SHIFT_INSTR_EN. Rev 1.0             |
// +----------------------------------------------------------------------+
`default_nettype none

module control_unit #(
  parameter logic [1:0] EXC_NONE   = 2'd0,
  parameter logic [1:0] EXC_OPCODE = 2'd1,
  parameter logic [1:0] EXC_OVF    = 2'd2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  control_unit_if.master   bus
);

  localparam logic [5:0] c_OP_R    = 6'h00;
  localparam logic [5:0] c_OP_J    = 6'h02;
  localparam logic [5:0] c_OP_JAL  = 6'h03;
  localparam logic [5:0] c_OP_BEQ  = 6'h04;
  localparam logic [5:0] c_OP_BNE  = 6'h05;
  localparam logic [5:0] c_OP_ADDI = 6'h08;
  localparam logic [5:0] c_OP_LW   = 6'h23;
  localparam logic [5:0] c_OP_SW   = 6'h2B;
  localparam logic [5:0] c_FN_ADD  = 6'h20;
  localparam logic [5:0] c_FN_SUB  = 6'h22;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_JR   = 6'h08;
`ifdef SHIFT_INSTR_EN
  localparam logic [5:0] c_FN_SLL  = 6'h00;
  localparam logic [5:0] c_FN_SRL  = 6'h02;
  localparam logic [5:0] c_FN_SRA  = 6'h03;
`endif

  typedef enum logic [4:0] {
    S_RST     = 5'd0,
    S_FETCH   = 5'd1,
    S_FWAIT   = 5'd2,
    S_DECODE  = 5'd3,
    S_EXEC_R  = 5'd4,
    S_WB_R    = 5'd5,
    S_JR      = 5'd6,
    S_EXEC_I  = 5'd7,
    S_WB_I    = 5'd8,
    S_ADDR    = 5'd9,
    S_MRD     = 5'd10,
    S_MWAIT   = 5'd11,
    S_WB_LW   = 5'd12,
    S_MWR     = 5'd13,
    S_BRANCH  = 5'd14,
    S_JUMP    = 5'd15,
    S_LINK    = 5'd16,
    S_EXC_EPC = 5'd17,
    S_EXC_JMP = 5'd18
`ifdef SHIFT_INSTR_EN
    ,
    S_SH_LD   = 5'd19,
    S_SH_OP   = 5'd20,
    S_SH_WB   = 5'd21
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_exc_cause;
  logic [1:0] w_cause;

  // Cause is captured only when entering EXC_EPC, so it stays sticky afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RST;
      r_exc_cause <= EXC_NONE;
    end else begin
      r_state <= w_next;
      if (w_next == S_EXC_EPC) r_exc_cause <= w_cause;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_cause           = EXC_NONE;
    bus.PCWrite       = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.EQorNE        = 1'b0;
    bus.MemRead_Write = 1'b0;
    bus.WDSrc         = 1'b0;
    bus.IorD          = 3'd0;
    bus.MDR           = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegALoad      = 1'b0;
    bus.RegBLoad      = 1'b0;
    bus.ALUOutLoad    = 1'b0;
    bus.EPCWrite      = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.RegDst        = 2'd0;
    bus.MemtoReg      = 4'd0;
    bus.ALUSrcA       = 1'b0;
    bus.ALUSrcB       = 2'd0;
    bus.ALUOp         = 3'b000;
    bus.PCSrc         = 3'd0;
    bus.ShiftType     = 3'b000;
    bus.ShiftQnt      = 2'd0;
    bus.ShiftReg      = 2'd0;
    bus.ExcCause      = r_exc_cause;
    bus.State         = r_state;

    case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        bus.ALUSrcB = 2'd1;
        bus.ALUOp   = 3'b001;
        bus.PCWrite = 1'b1;
        w_next      = S_FWAIT;
      end
      S_FWAIT: begin
        bus.IRWrite = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        bus.RegALoad   = 1'b1;
        bus.RegBLoad   = 1'b1;
        bus.ALUSrcB    = 2'd3;
        bus.ALUOp      = 3'b001;
        bus.ALUOutLoad = 1'b1;
        w_next         = S_EXC_EPC;
        w_cause        = EXC_OPCODE;
        case (bus.Opcode)
          c_OP_R: begin
            case (bus.Funct)
              c_FN_ADD, c_FN_SUB, c_FN_AND: w_next = S_EXEC_R;
              c_FN_JR:                      w_next = S_JR;
`ifdef SHIFT_INSTR_EN
              c_FN_SLL, c_FN_SRL, c_FN_SRA: w_next = S_SH_LD;
`endif
              default:                      w_next = S_EXC_EPC;
            endcase
          end
          c_OP_ADDI:          w_next = S_EXEC_I;
          c_OP_LW, c_OP_SW:   w_next = S_ADDR;
          c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
          c_OP_J:             w_next = S_JUMP;
          c_OP_JAL:           w_next = S_LINK;
          default:            w_next = S_EXC_EPC;
        endcase
      end
      S_EXEC_R: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUOutLoad = 1'b1;
        case (bus.Funct)
          c_FN_SUB: bus.ALUOp = 3'b010;
          c_FN_AND: bus.ALUOp = 3'b011;
          default:  bus.ALUOp = 3'b001;
        endcase
        if (bus.Overflow && (bus.Funct == c_FN_ADD || bus.Funct == c_FN_SUB)) begin
          w_next  = S_EXC_EPC;
          w_cause = EXC_OVF;
        end else begin
          w_next = S_WB_R;
        end
      end
      S_WB_R: begin
        bus.RegDst   = 2'd1;
        bus.RegWrite = 1'b1;
        w_next       = S_FETCH;
      end
      S_JR: begin
        bus.ALUSrcA = 1'b1;
        bus.PCWrite = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXEC_I, S_ADDR: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'd2;
        bus.ALUOp      = 3'b001;
        bus.ALUOutLoad = 1'b1;
        if (r_state == S_ADDR)
          w_next = (bus.Opcode == c_OP_SW) ? S_MWR : S_MRD;
        else if (bus.Overflow) begin
          w_next  = S_EXC_EPC;
          w_cause = EXC_OVF;
        end else
          w_next = S_WB_I;
      end
      S_WB_I: begin
        bus.RegWrite = 1'b1;
        w_next       = S_FETCH;
      end
      S_MRD: begin
        bus.IorD = 3'd1;
        w_next   = S_MWAIT;
      end
      S_MWAIT: begin
        bus.MDR = 1'b1;
        w_next  = S_WB_LW;
      end
      S_WB_LW: begin
        bus.MemtoReg = 4'd1;
        bus.RegWrite = 1'b1;
        w_next       = S_FETCH;
      end
      S_MWR: begin
        bus.IorD          = 3'd1;
        bus.MemRead_Write = 1'b1;
        w_next            = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 3'b010;
        bus.PCSrc       = 3'd1;
        bus.PCWriteCond = 1'b1;
        bus.EQorNE      = (bus.Opcode == c_OP_BNE);
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        bus.PCSrc   = 3'd2;
        bus.PCWrite = 1'b1;
        w_next      = S_FETCH;
      end
      S_LINK: begin
        bus.RegDst   = 2'd2;
        bus.MemtoReg = 4'd6;
        bus.RegWrite = 1'b1;
        w_next       = S_JUMP;
      end
      S_EXC_EPC: begin
        bus.ALUSrcB  = 2'd1;
        bus.ALUOp    = 3'b010;
        bus.EPCWrite = 1'b1;
        w_next       = S_EXC_JMP;
      end
      S_EXC_JMP: begin
        bus.PCSrc   = 3'd5;
        bus.PCWrite = 1'b1;
        w_next      = S_FETCH;
      end
`ifdef SHIFT_INSTR_EN
      S_SH_LD: begin
        bus.ShiftReg  = 2'd2;
        bus.ShiftQnt  = 2'd1;
        bus.ShiftType = 3'b001;
        w_next        = S_SH_OP;
      end
      S_SH_OP: begin
        case (bus.Funct)
          c_FN_SRL: bus.ShiftType = 3'b011;
          c_FN_SRA: bus.ShiftType = 3'b100;
          default:  bus.ShiftType = 3'b010;
        endcase
        w_next = S_SH_WB;
      end
      S_SH_WB: begin
        bus.RegDst   = 2'd1;
        bus.MemtoReg = 4'd3;
        bus.RegWrite = 1'b1;
        w_next       = S_FETCH;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multicycle control FSM for the MIPS-subset CPU. It sits opposite the datapath: it consumes the instruction fields and ALU status that the datapath produces, and it drives every mux select, register load and memory/ALU/shifter command the datapath consumes. Each instruction runs as a fixed sequence of states, entered from a shared fetch/decode prefix. Overflow and invalid opcodes are routed to an EPC-saving exception sequence.

## Interface
Parameters:
- `EXC_NONE` = 2'd0: ExcCause value when no exception has occurred.
- `EXC_OPCODE` = 2'd1: ExcCause value for an invalid opcode or funct.
- `EXC_OVF` = 2'd2: ExcCause value for arithmetic overflow.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `Opcode` in 6: IR[31:26].
- `Funct` in 6: IR[5:0], taken from Imediato[5:0].
- `Overflow` in 1: Ula32 overflow flag, combinational.
- `PCWrite`, `PCWriteCond`, `EQorNE` out 1 each: PC write controls, feeding pc_sel.
- `MemRead_Write` out 1: 0 = read, 1 = write.
- `WDSrc` out 1: memory write-data mux select.
- `IorD` out 3: memory address select. 0 = PC, 1 = ALUOut, 2 = A, 3 = B.
- `MDR`, `IRWrite`, `RegALoad`, `RegBLoad`, `ALUOutLoad`, `EPCWrite`, `RegWrite` out 1 each: register load enables.
- `RegDst` out 2: write register select. 0 = rt, 1 = rd, 2 = $31.
- `MemtoReg` out 4: register write-data select. 0 = ALUOut, 1 = MDR, 3 = Shifter, 6 = PC.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 0 = B, 1 = constant 4, 2 = imm sign-extended, 3 = imm sign-extended << 2.
- `ALUOp` out 3: Ula32 code. 000 = load A, 001 = add, 010 = sub, 011 = and.
- `PCSrc` out 3: PC source select. 0 = ALUResult, 1 = ALUOut, 2 = jump target, 5 = exception vector.
- `ShiftType` out 3, `ShiftQnt` out 2, `ShiftReg` out 2: RegDesloc controls.
- `ExcCause` out 2: sticky cause of the most recent exception.
- `State` out 5: current state, for debug only.

## Operation
- Outputs are a Moore decode of the state register and the Opcode/Funct fields. Any output not listed for a state is 0.
- **RST**: held while `rst`=0. All outputs are 0 and `ExcCause`=0. The first edge after release goes to FETCH.
- **FETCH**: IorD=0, read, ALUSrcA=0, ALUSrcB=1, ALUOp=001, PCSrc=0, PCWrite. Next state is FWAIT.
- **FWAIT**: IRWrite. Next state is DECODE.
- **DECODE**: RegALoad, RegBLoad, ALUSrcA=0, ALUSrcB=3, ALUOp=001, ALUOutLoad (this computes the branch target). Dispatch on Opcode/Funct.
- R-type (op 0x00):
  - funct 0x20 (add), 0x22 (sub), 0x24 (and) → **EXEC_R**: ALUSrcA=1, ALUSrcB=0, ALUOp 001/010/011, ALUOutLoad.
    - From EXEC_R, go to EXC_EPC if Overflow=1 and funct is add/sub; otherwise go to **WB_R**.
    - WB_R: RegDst=1, MemtoReg=0, RegWrite. Next state is FETCH.
  - funct 0x08 (jr) → **JR**: ALUSrcA=1, ALUOp=000, PCSrc=0, PCWrite. Next state is FETCH.
- addi (0x08) → **EXEC_I**: ALUSrcA=1, ALUSrcB=2, ALUOp=001, ALUOutLoad.
  - Go to EXC_EPC if Overflow=1; otherwise go to **WB_I**.
  - WB_I: RegDst=0, MemtoReg=0, RegWrite. Next state is FETCH.
- lw (0x23) / sw (0x2B) → **ADDR**: same controls as EXEC_I, overflow ignored.
  - lw: **MRD** (IorD=1, read) → **MWAIT** (MDR) → **WB_LW** (RegDst=0, MemtoReg=1, RegWrite) → FETCH.
  - sw: **MWR** (IorD=1, MemRead_Write=1, WDSrc=0) → FETCH.
- beq (0x04) / bne (0x05) → **BRANCH**: ALUSrcA=1, ALUSrcB=0, ALUOp=010, PCSrc=1, PCWriteCond. EQorNE=0 for beq, 1 for bne. Next state is FETCH.
- j (0x02) → **JUMP**: PCSrc=2, PCWrite. Next state is FETCH.
- jal (0x03) → **LINK** (RegDst=2, MemtoReg=6, RegWrite) → JUMP.
- Any other opcode or funct → EXC_EPC with cause EXC_OPCODE.
- **EXC_EPC**: ALUSrcA=0, ALUSrcB=1, ALUOp=010, EPCWrite, so EPC = PC−4 (the faulting instruction). `ExcCause` is registered on entry. Next state is **EXC_JMP**.
- **EXC_JMP**: PCSrc=5, PCWrite. Next state is FETCH.

## Timing
- Cycle counts, FETCH through the last state inclusive:
  - 4 cycles: j, jr, beq, bne.
  - 5 cycles: add/sub/and, addi, sw, jal.
  - 7 cycles: lw.
  - 6 cycles: shift.
  - Exception: DECODE/EXEC plus 2 cycles.
- Overflow is sampled only at the EXEC_R/EXEC_I clock edge. A faulting instruction never asserts RegWrite.
- `rst` low at any point forces RST immediately, asynchronously. Any multi-cycle sequence is abandoned, and no write strobe is asserted in that cycle.
- `ExcCause` holds its value until the next exception or reset.

## Configuration
- `SHIFT_INSTR_EN` defined: R-type funct 0x00 (sll), 0x02 (srl) and 0x03 (sra) are supported.
  - **SH_LD**: ShiftReg=2 (B), ShiftQnt=1 (shamt), ShiftType=001.
  - **SH_OP**: ShiftType 010/011/100 for sll/srl/sra.
  - **SH_WB**: RegDst=1, MemtoReg=3, RegWrite. Next state is FETCH.
- `SHIFT_INSTR_EN` undefined: those funct codes raise EXC_OPCODE. This includes the all-zero NOP. The shift states are absent, and ShiftType, ShiftQnt and ShiftReg are tied to 0.

## Test plan
- Hold `rst`=0 for 3 cycles, then release → State=RST and all outputs 0 while held; the first edge after release enters FETCH with PCWrite=1.
- add with no overflow (op 0x00, funct 0x20) → states FETCH, FWAIT, DECODE, EXEC_R, WB_R. RegWrite=1 only in WB_R, with RegDst=1. The next state is FETCH.
- addi with Overflow=1 in EXEC_I → EXC_EPC with EPCWrite=1 and ExcCause=2, then EXC_JMP with PCSrc=5. RegWrite is never asserted.
- lw (0x23) → a 7-cycle sequence: MRD has IorD=1, MWAIT has MDR=1, WB_LW has MemtoReg=1.
- bne (0x05) → BRANCH asserts PCWriteCond=1, EQorNE=1, PCSrc=1. jal (0x03) → LINK with RegDst=2 and MemtoReg=6, then JUMP with PCSrc=2.
- Opcode 0x3F → ExcCause=1. Pull `rst` low during MWAIT of an lw → immediate RST with no strobes; sll behaviour matches the SHIFT_INSTR_EN setting.
